// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer: walks a parameter table of I2C write/delay entries
// and feeds {address, byte} write strobes into the I2C FIFO stage.
//
// Ports:
//   CLK_IW    clock, rising edge
//   RST_IW    asynchronous active-low reset
//   RUN_IW    start request, sampled only while idle
//   FULL_IW   FIFO full flag, throttles write strobes
//   READY_IW  I2C master idle flag, used to drain before delays/done
//   START_OW  one-cycle FIFO write strobe per write entry
//   ADDR_OW   7-bit device address, valid with START_OW
//   DATA_OW   data byte, valid with START_OW
//   BUSY_OW   high from RUN acceptance until DONE_OW
//   DONE_OW   one-cycle pulse once the last byte has left the master
//
// Table entry i = INIT_SEQ[9*i+8 : 9*i]:
//   bit8=0 -> write bits[7:0]
//   bit8=1 -> delay bits[7:0] * TICK_CYCLES clock cycles
module i2c_init_sequencer #(
    parameter int                     CMD_COUNT   = 8,
    parameter logic [6:0]             DEV_ADDR    = 7'h3C,
    parameter int                     TICK_CYCLES = 1000,
    parameter logic [CMD_COUNT*9-1:0] INIT_SEQ    = {CMD_COUNT{9'h000}}
) (
    input  logic       CLK_IW,
    input  logic       RST_IW,
    input  logic       RUN_IW,
    input  logic       FULL_IW,
    input  logic       READY_IW,
    output logic       START_OW,
    output logic [6:0] ADDR_OW,
    output logic [7:0] DATA_OW,
    output logic       BUSY_OW,
    output logic       DONE_OW
);

    localparam int IDX_W  = (CMD_COUNT > 1) ? $clog2(CMD_COUNT) : 1;
    // Wide enough for 255 * TICK_CYCLES
    localparam int WAIT_W = 8 + $clog2(TICK_CYCLES + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CMD_COUNT - 1);
    localparam logic [WAIT_W-1:0] TICK_W   = WAIT_W'(TICK_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_PUSH   = 3'd2,
        S_DRAIN  = 3'd3,
        S_WAIT   = 3'd4,
        S_FINISH = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                rdy_seen_q, rdy_seen_d;
    logic                drain_end_q, drain_end_d;
    logic                start_q, start_d;
    logic [6:0]          addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [8:0]          entry_w;
    logic [WAIT_W-1:0]   wait_load_w;
    logic                adv_w;

    // Table lookup; the loop keeps the select in range for any CMD_COUNT
    always_comb begin
        entry_w = 9'h000;
        for (int i = 0; i < CMD_COUNT; i++) begin
            if (idx_q == IDX_W'(i)) begin
                entry_w = INIT_SEQ[9*i +: 9];
            end
        end
    end

    assign wait_load_w = {{(WAIT_W-8){1'b0}}, entry_w[7:0]} * TICK_W;

    always_ff @(posedge CLK_IW or negedge RST_IW) begin
        if (!RST_IW) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            wait_q      <= '0;
            rdy_seen_q  <= 1'b0;
            drain_end_q <= 1'b0;
            start_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            rdy_seen_q  <= rdy_seen_d;
            drain_end_q <= drain_end_d;
            start_q     <= start_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        rdy_seen_d  = rdy_seen_q;
        drain_end_d = drain_end_q;
        start_d     = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        adv_w       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (RUN_IW) begin
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                if (entry_w[8]) begin
                    drain_end_d = 1'b0;
                    rdy_seen_d  = 1'b0;
                    state_d     = S_DRAIN;
                end else begin
                    state_d = S_PUSH;
                end
            end

            // Strobe is registered, and the FETCH that follows keeps
            // successive decisions at least two cycles apart.
            S_PUSH: begin
                if (!FULL_IW) begin
                    start_d = 1'b1;
                    addr_d  = DEV_ADDR;
                    data_d  = entry_w[7:0];
                    adv_w   = 1'b1;
                end
            end

            // Two consecutive READY samples: FIFO empty and master idle
            S_DRAIN: begin
                if (!READY_IW) begin
                    rdy_seen_d = 1'b0;
                end else if (!rdy_seen_q) begin
                    rdy_seen_d = 1'b1;
                end else begin
                    rdy_seen_d = 1'b0;
                    if (drain_end_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FINISH;
                    end else if (wait_load_w == '0) begin
                        adv_w = 1'b1;
                    end else begin
                        wait_d  = wait_load_w;
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (wait_q <= WAIT_W'(1)) begin
                    wait_d = '0;
                    adv_w  = 1'b1;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Index advance: next entry, or final drain after the last one
        if (adv_w) begin
            if (idx_q != LAST_IDX) begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = S_FETCH;
            end else begin
                drain_end_d = 1'b1;
                rdy_seen_d  = 1'b0;
                state_d     = S_DRAIN;
            end
        end
    end

    assign START_OW = start_q;
    assign ADDR_OW  = addr_q;
    assign DATA_OW  = data_q;
    assign BUSY_OW  = busy_q;
    assign DONE_OW  = done_q;

endmodule
